// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NREQ byte sources; sequences start/ready per byte.
// Optional macro ARB_LOCK_EN adds a per-requester lock input that keeps ownership across consecutive bytes.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]   lock,
`endif
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              busy,
    output logic              err
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t            r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [NREQ-1:0]   r_ack;
    logic [NREQ-1:0]   r_grant;
    logic              r_tx_start;
    logic [7:0]        r_tx_data;
    logic              r_busy;
    logic              r_err;
`ifdef ARB_LOCK_EN
    logic              r_lock_ok;
`endif

    int                w_start;
    int                w_best;
    logic              w_found;
    logic [PTR_W-1:0]  w_winner;
    logic [NREQ-1:0]   w_onehot;
    logic [7:0]        w_sel_data;

    // Rotational distance of requester idx from the scan start position.
    function automatic int f_dist(input int idx, input int start);
        return (idx - start + 2 * NREQ) % NREQ;
    endfunction

    always_comb begin
`ifdef ARB_LOCK_EN
        w_start = (r_lock_ok && lock[r_ptr]) ? int'(r_ptr) : int'(r_ptr) + 1;
`else
        w_start = int'(r_ptr) + 1;
`endif
        w_best     = NREQ;
        w_found    = 1'b0;
        w_winner   = '0;
        w_onehot   = '0;
        w_sel_data = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && (f_dist(i, w_start) < w_best)) begin
                w_best      = f_dist(i, w_start);
                w_found     = 1'b1;
                w_winner    = PTR_W'(i);
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
                w_sel_data  = req_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_ptr      <= PTR_W'(NREQ - 1);
            r_cnt      <= '0;
            r_ack      <= '0;
            r_grant    <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
`ifdef ARB_LOCK_EN
            r_lock_ok  <= 1'b0;
`endif
        end else begin
            r_ack      <= '0;
            r_tx_start <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tx_ready && w_found) begin
                        r_tx_data  <= w_sel_data;
                        r_grant    <= w_onehot;
                        r_ack      <= w_onehot;
                        r_tx_start <= 1'b1;
                        r_ptr      <= w_winner;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!tx_ready) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        // Transmitter never accepted the byte: give up and drop ownership.
                        r_err     <= 1'b1;
                        r_grant   <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
`ifdef ARB_LOCK_EN
                        r_lock_ok <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_ready) begin
                        r_grant   <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
`ifdef ARB_LOCK_EN
                        r_lock_ok <= 1'b1;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack      = r_ack;
    assign grant    = r_grant;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule
